reg_bus_arb: RTL and testbench

// - Shares the single register-file bus (wr_en/addr/be/wr_data/rd_en -> rd_rdy/rd_data) between NUM_REQ masters.
// - Typical masters: UART command decoder and on-chip debug/self-test sequencer.
// - Arbitration is round-robin, with one outstanding transaction on the bus at a time.
// - Masters get a per-transaction response, with a timeout if rd_rdy never returns.

---
 rtl/reg_bus_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/reg_bus_arb.sv | 185 ++++++++++++++++++
 tb/tb_reg_bus_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-file bus: widths, arbiter state encoding
// and a helper for index widths. Also imported by the register file and UART decoder.
package reg_bus_pkg;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after i_last, wrapping.
// Reusable for any shared resource with a registered last-grant pointer.
module rr_arbiter
  import reg_bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Offset k walks the ring starting just after the last winner.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!o_any && i_req[j] && (((int'(i_last) + k) % N) == j)) begin
          o_any      = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/reg_bus_arb.sv
// Round-robin arbiter sharing the register-file bus between NUM_REQ masters,
// one transaction in flight, with a read-data timeout producing an error response.
//
// state | meaning
// IDLE  | waiting for any req_valid; grant issued combinationally
// ISSUE | one-cycle wr_en or rd_en with the latched request
// WAIT  | read outstanding; waiting for rd_rdy or timeout
// RESP  | one-cycle rsp_valid to the granted master
module reg_bus_arb
  import reg_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = BUS_AW,
  parameter int DW      = BUS_DW,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]  req_be,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_err,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [AW-1:0]         addr,
  output logic [3:0]            be,
  output logic [DW-1:0]         wr_data,
  input  logic                  rd_rdy,
  input  logic [DW-1:0]         rd_data
);

  localparam int            IW       = idx_width(NUM_REQ);
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IW-1:0]      r_last_grant;
  logic [NUM_REQ-1:0] r_grant_oh;
  logic               r_wr;
  logic [AW-1:0]      r_addr;
  logic [3:0]         r_be;
  logic [DW-1:0]      r_wdata;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_err;
  logic [DW-1:0]      r_rsp_rdata;

  logic [NUM_REQ-1:0] w_grant_oh;
  logic [IW-1:0]      w_grant_idx;
  logic               w_any;
  logic               w_sel_wr;
  logic [AW-1:0]      w_sel_addr;
  logic [3:0]         w_sel_be;
  logic [DW-1:0]      w_sel_wdata;
  logic               w_accept;
  logic               w_to_resp;
  logic               w_rsp_err;
  logic [DW-1:0]      w_rsp_rdata;
  logic               w_cnt_clr;
  logic               w_cnt_inc;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .i_req   (req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_grant_oh),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_be    = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_oh[i]) begin
        w_sel_wr    = req_wr[i];
        w_sel_addr  = req_addr[i*AW +: AW];
        w_sel_be    = req_be[i*4 +: 4];
        w_sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    w_accept    = 1'b0;
    w_to_resp   = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by rst so req_ready also reads 0 while reset is held.
        if (w_any && !rst) begin
          req_ready   = w_grant_oh;
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        wr_en = r_wr;
        rd_en = !r_wr;
        if (r_wr) begin
          w_to_resp   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Data arriving on the expiry cycle still counts as a good read.
        if (rd_rdy) begin
          w_to_resp   = 1'b1;
          w_rsp_rdata = rd_data;
          w_state_nxt = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_to_resp   = 1'b1;
          w_rsp_err   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= IW'(NUM_REQ - 1);
      r_grant_oh   <= '0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      r_rsp_valid <= w_to_resp ? r_grant_oh : '0;
      r_rsp_err   <= w_to_resp & w_rsp_err;
      r_rsp_rdata <= w_to_resp ? w_rsp_rdata : '0;
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_grant_oh   <= w_grant_oh;
        r_wr         <= w_sel_wr;
        r_addr       <= w_sel_addr;
        r_be         <= w_sel_be;
        r_wdata      <= w_sel_wdata;
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign addr      = r_addr;
  assign be        = r_be;
  assign wr_data   = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed bench for reg_bus_arb: a timestamp-level transaction model checked every
// cycle, plus literal checks on latency, round-robin order, timeout and reset.
module tb_reg_bus_arb;

  localparam int NUM_REQ = 2;
  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*4-1:0]  req_be;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic                  rsp_err;
  logic [DW-1:0]         rsp_rdata;
  logic                  wr_en;
  logic                  rd_en;
  logic [AW-1:0]         addr;
  logic [3:0]            be;
  logic [DW-1:0]         wr_data;
  logic                  rd_rdy = 1'b0;
  logic [DW-1:0]         rd_data = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int            rdy_delay = 0;
  int            rd_due    = -1;
  int            stray_lo  = -1;
  int            stray_hi  = -2;
  logic [DW-1:0] bus_rdata = '0;

  bit            m_busy = 1'b0;
  bit            m_wr, m_rsp_set, m_err;
  int            m_acc, m_rsp_cyc, m_g;
  int            m_last = NUM_REQ - 1;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_be;
  logic [DW-1:0] m_wd, m_rdata;

  reg_bus_arb #(
    .NUM_REQ (NUM_REQ),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .be        (be),
    .wr_data   (wr_data),
    .rd_rdy    (rd_rdy),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Register-file responder: rd_rdy rdy_delay cycles after rd_en, plus optional stray pulses.
  always @(posedge clk) begin
    #2;
    if (rd_due >= 0 && cyc == rd_due) begin
      rd_rdy  = 1'b1;
      rd_data = bus_rdata;
    end else if (cyc >= stray_lo && cyc <= stray_hi) begin
      rd_rdy  = 1'b1;
      rd_data = 32'hDEAD_BEEF;
    end else begin
      rd_rdy  = 1'b0;
      rd_data = '0;
    end
  end

  // Model: one transaction at a time, timed from its accept cycle.
  always @(negedge clk) begin : mon
    logic [NUM_REQ-1:0] e_ready, e_rsp;
    logic e_wr, e_rd;
    bit done;
    int pick;
    e_ready = '0; e_rsp = '0; e_wr = 1'b0; e_rd = 1'b0; done = 1'b0; pick = -1;
    if (rst) begin
      m_busy = 1'b0;
      m_last = NUM_REQ - 1;
      rd_due = -1;
      chk("mon_reset_outputs", 128'({req_ready, rsp_valid, rsp_err, rsp_rdata, wr_en, rd_en,
                                     addr, be, wr_data}), 128'(0));
    end else begin
      if (m_busy) begin
        if (cyc == m_acc + 1) begin
          e_wr = m_wr;
          e_rd = !m_wr;
        end
        if (!m_rsp_set && !m_wr && cyc >= m_acc + 2) begin
          if (rd_rdy) begin
            m_rsp_set = 1'b1; m_rsp_cyc = cyc + 1; m_err = 1'b0; m_rdata = rd_data;
          end else if (cyc == m_acc + 1 + TIMEOUT) begin
            m_rsp_set = 1'b1; m_rsp_cyc = cyc + 1; m_err = 1'b1; m_rdata = '0;
          end
        end
        if (m_rsp_set && cyc == m_rsp_cyc) begin
          e_rsp[m_g] = 1'b1;
          done = 1'b1;
        end
      end else begin
        for (int k = 1; k <= NUM_REQ; k++)
          if (pick < 0 && req_valid[(m_last + k) % NUM_REQ]) pick = (m_last + k) % NUM_REQ;
        if (pick >= 0) begin
          e_ready[pick] = 1'b1;
          m_busy  = 1'b1;
          m_acc   = cyc;
          m_g     = pick;
          m_last  = pick;
          m_wr    = req_wr[pick];
          m_addr  = req_addr[pick*AW +: AW];
          m_be    = req_be[pick*4 +: 4];
          m_wd    = req_wdata[pick*DW +: DW];
          m_rsp_set = m_wr;
          m_rsp_cyc = cyc + 2;
          m_err   = 1'b0;
          m_rdata = '0;
        end
      end
      chk("mon_req_ready", 128'(req_ready), 128'(e_ready));
      chk("mon_wr_en", 128'(wr_en), 128'(e_wr));
      chk("mon_rd_en", 128'(rd_en), 128'(e_rd));
      chk("mon_rsp_valid", 128'(rsp_valid), 128'(e_rsp));
      if (e_wr || e_rd) begin
        chk("mon_addr", 128'(addr), 128'(m_addr));
        chk("mon_be", 128'(be), 128'(m_be));
      end
      if (e_wr) chk("mon_wr_data", 128'(wr_data), 128'(m_wd));
      if (done) begin
        chk("mon_rsp_err", 128'(rsp_err), 128'(m_err));
        chk("mon_rsp_rdata", 128'(rsp_rdata), 128'(m_rdata));
        m_busy = 1'b0;
      end
      if (rd_en && rdy_delay > 0) rd_due = cyc + rdy_delay;
    end
  end

  task automatic do_txn(input int m, input bit wr, input logic [AW-1:0] a, input logic [3:0] b,
                        input logic [DW-1:0] d, output int t0);
    bit got;
    got = 1'b0;
    t0  = -1;
    @(posedge clk); #2;
    req_wr[m]              = wr;
    req_addr[m*AW +: AW]   = a;
    req_be[m*4 +: 4]       = b;
    req_wdata[m*DW +: DW]  = d;
    req_valid[m]           = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[m]) begin
        got = 1'b1;
        t0  = cyc;
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: master %0d never saw req_ready, expected accept within 40 cycles", m);
    end
    @(posedge clk); #2;
    req_valid[m] = 1'b0;
  endtask

  task automatic wait_rsp(input int t0, output int lat, output logic [NUM_REQ-1:0] rv,
                          output logic err, output logic [DW-1:0] rd);
    bit got;
    got = 1'b0; lat = -1; rv = '0; err = 1'b0; rd = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        got = 1'b1;
        lat = cyc - t0;
        rv  = rsp_valid;
        err = rsp_err;
        rd  = rsp_rdata;
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid seen, expected one within 40 cycles of cycle %0d", t0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 100us");
    $fatal(1);
  end

  initial begin
    int t0, tp, lat;
    logic [NUM_REQ-1:0] rv;
    logic e;
    logic [DW-1:0] d;
    bit got;

    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_be = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 128'({req_ready, rsp_valid, rsp_err, rsp_rdata, wr_en, rd_en,
                             addr, be, wr_data}), 128'(0));
    @(posedge clk); #2;
    rst = 1'b0;

    // Single write, master 0
    do_txn(0, 1'b1, 16'h0000, 4'hF, 32'h0000_01A5, t0);
    @(negedge clk);
    chk("t1_wr_en", 128'(wr_en), 128'(1));
    chk("t1_rd_en", 128'(rd_en), 128'(0));
    chk("t1_wr_data", 128'(wr_data), 128'(32'h0000_01A5));
    chk("t1_be", 128'(be), 128'(4'hF));
    wait_rsp(t0, lat, rv, e, d);
    chk("t1_rsp_lat", 128'(lat), 128'(2));
    chk("t1_rsp_valid", 128'(rv), 128'(2'b01));
    chk("t1_rsp_err", 128'(e), 128'(0));

    // Single read, master 1, one-cycle register file
    rdy_delay = 1;
    bus_rdata = 32'h5A00_0012;
    do_txn(1, 1'b0, 16'h0040, 4'hF, 32'h0, t0);
    @(negedge clk);
    chk("t2_rd_en", 128'(rd_en), 128'(1));
    chk("t2_addr", 128'(addr), 128'(16'h0040));
    wait_rsp(t0, lat, rv, e, d);
    chk("t2_rsp_lat", 128'(lat), 128'(3));
    chk("t2_rsp_valid", 128'(rv), 128'(2'b10));
    chk("t2_rsp_rdata", 128'(d), 128'(32'h5A00_0012));
    chk("t2_rsp_err", 128'(e), 128'(0));

    // Both masters streaming writes from reset
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    req_wr = 2'b11;
    req_addr = {16'h0020, 16'h0010};
    req_be = 8'hFF;
    req_wdata = {32'h2222_0000, 32'h1111_0000};
    req_valid = 2'b11;
    tp = 0;
    for (int i = 0; i < 8; i++) begin
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        if (req_ready != '0) got = 1'b1;
      end
      chk($sformatf("rr_grant_%0d", i), 128'(req_ready), 128'((i % 2 == 0) ? 2'b01 : 2'b10));
      if (i > 0) chk($sformatf("rr_spacing_%0d", i), 128'(cyc - tp), 128'(3));
      tp = cyc;
    end
    @(posedge clk); #2;
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Read that never returns: timeout error, then a normal write
    rdy_delay = 0;
    do_txn(0, 1'b0, 16'h0200, 4'h3, 32'h0, t0);
    wait_rsp(t0, lat, rv, e, d);
    chk("t4_rsp_lat", 128'(lat), 128'(2 + TIMEOUT));
    chk("t4_rsp_valid", 128'(rv), 128'(2'b01));
    chk("t4_rsp_err", 128'(e), 128'(1));
    chk("t4_rsp_rdata", 128'(d), 128'(0));
    do_txn(1, 1'b1, 16'h0204, 4'hF, 32'h1234_5678, t0);
    wait_rsp(t0, lat, rv, e, d);
    chk("t4_next_lat", 128'(lat), 128'(2));
    chk("t4_next_valid", 128'(rv), 128'(2'b10));

    // Stray rd_rdy in IDLE, then during a write
    @(posedge clk); #2;
    stray_lo = cyc + 1; stray_hi = cyc + 3;
    repeat (5) @(negedge clk);
    chk("t5_idle_stray_rsp", 128'(rsp_valid), 128'(0));
    @(posedge clk); #2;
    stray_lo = cyc + 1; stray_hi = cyc + 5;
    do_txn(0, 1'b1, 16'h0300, 4'hC, 32'hAAAA_5555, t0);
    wait_rsp(t0, lat, rv, e, d);
    chk("t5_wr_stray_lat", 128'(lat), 128'(2));
    chk("t5_wr_stray_rdata", 128'(d), 128'(0));
    chk("t5_wr_stray_err", 128'(e), 128'(0));
    stray_lo = -1; stray_hi = -2;
    repeat (4) @(negedge clk);

    // rd_rdy exactly on the expiry cycle: data wins
    rdy_delay = TIMEOUT;
    bus_rdata = 32'hC0FF_EE15;
    do_txn(1, 1'b0, 16'h0100, 4'hF, 32'h0, t0);
    wait_rsp(t0, lat, rv, e, d);
    chk("t5_expiry_lat", 128'(lat), 128'(2 + TIMEOUT));
    chk("t5_expiry_err", 128'(e), 128'(0));
    chk("t5_expiry_rdata", 128'(d), 128'(32'hC0FF_EE15));

    // rd_rdy one cycle too late: error, and the late pulse lands in RESP
    rdy_delay = TIMEOUT + 1;
    bus_rdata = 32'h0BAD_0016;
    do_txn(0, 1'b0, 16'h0104, 4'hF, 32'h0, t0);
    wait_rsp(t0, lat, rv, e, d);
    chk("t5_late_lat", 128'(lat), 128'(2 + TIMEOUT));
    chk("t5_late_err", 128'(e), 128'(1));
    chk("t5_late_rdata", 128'(d), 128'(0));
    repeat (4) @(negedge clk);

    // Reset during WAIT
    rdy_delay = 0;
    do_txn(0, 1'b0, 16'h1234, 4'hA, 32'h0, t0);
    repeat (2) @(negedge clk);
    chk("t6_addr_held", 128'(addr), 128'(16'h1234));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_async", 128'({req_ready, rsp_valid, rsp_err, rsp_rdata, wr_en, rd_en,
                              addr, be, wr_data}), 128'(0));
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    req_wr = 2'b11;
    req_valid = 2'b11;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        t0  = cyc;
      end
    end
    chk("t6_first_after_rst", 128'(req_ready), 128'(2'b01));
    @(posedge clk); #2;
    req_valid = '0;
    wait_rsp(t0, lat, rv, e, d);
    chk("t6_rsp_lat", 128'(lat), 128'(2));
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
